matrix_mac_nxn: RTL and testbench

//  Parametrised NxN matrix multiply-accumulate engine: C = A*B, or C += A*B in accumulate mode.

---
 rtl/matrix_mac_pkg.sv | 20 ++
 rtl/matrix_mac_nxn_mac_unit.sv | 29 ++
 rtl/matrix_mac_nxn.sv | 147 ++++++++++++++
 tb/tb_matrix_mac_nxn.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_mac_pkg
//  Purpose  : Shared FSM state type and operand-select encoding for matrix_mac_nxn
//  Revision : 1.0  initial release
// ============================================================================
package matrix_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/matrix_mac_nxn_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mac_unit
//  Purpose  : Combinational signed/unsigned multiply of two operands plus accumulate
//  Revision : 1.0  initial release
// ============================================================================
module mac_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic [DW-1:0]    i_a,
  input  logic [DW-1:0]    i_b,
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_signed,
  output logic [ACC_W-1:0] o_acc
);

  logic [ACC_W-1:0] w_a_ext;
  logic [ACC_W-1:0] w_b_ext;
  logic [ACC_W-1:0] w_prod;

  // Extending both operands to ACC_W first keeps the product exact modulo 2^ACC_W
  assign w_a_ext = {{(ACC_W-DW){i_signed & i_a[DW-1]}}, i_a};
  assign w_b_ext = {{(ACC_W-DW){i_signed & i_b[DW-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign o_acc   = i_acc + w_prod;

endmodule
`default_nettype wire

// File: rtl/matrix_mac_nxn.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_mac_nxn
//  Purpose  : NxN matrix multiply-accumulate engine, one MAC per cycle, host-loadable A/B
//  Revision : 1.0  initial release
// ============================================================================
module matrix_mac_nxn
  import matrix_mac_pkg::*;
#(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW + $clog2(N),
  parameter int IDX_W = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             start,
  input  logic             acc_mode,
  input  logic             signed_mode,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [ACC_W-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(N);
  localparam int NN = N*N;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_i, r_j, r_k;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_mac;
  logic             r_acc_mode;
  logic             r_signed;
  logic             r_busy;
  logic             r_done;
  logic [ACC_W-1:0] r_rd_data;
  logic [DW-1:0]    r_a [NN];
  logic [DW-1:0]    r_b [NN];
  logic [ACC_W-1:0] r_c [NN];

  logic             w_k_last, w_j_last, w_i_last;
  logic [IDX_W-1:0] w_a_idx, w_b_idx, w_c_idx;

  assign w_k_last = (r_k == CW'(N-1));
  assign w_j_last = (r_j == CW'(N-1));
  assign w_i_last = (r_i == CW'(N-1));
  assign w_a_idx  = IDX_W'(int'(r_i)*N + int'(r_k));
  assign w_b_idx  = IDX_W'(int'(r_k)*N + int'(r_j));
  assign w_c_idx  = IDX_W'(int'(r_i)*N + int'(r_j));

  mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_a      (r_a[w_a_idx]),
    .i_b      (r_b[w_b_idx]),
    .i_acc    ((r_k == '0) ? '0 : r_acc),
    .i_signed (r_signed),
    .o_acc    (w_mac)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = MAC;
      MAC:     if (w_k_last) w_next = WRITE;
      WRITE:   w_next = (w_i_last && w_j_last) ? DONE : MAC;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_acc_mode <= 1'b0;
      r_signed   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= '0;
      for (int n = 0; n < NN; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
        r_c[n] <= '0;
      end
    end else begin
      r_done    <= 1'b0;
      r_rd_data <= (int'(rd_addr) < NN) ? r_c[rd_addr] : '0;
      case (r_state)
        IDLE: begin
          // Host writes land on the same edge that samples start, so the run sees them
          if (wr_en && int'(wr_addr) < NN) begin
            if (wr_sel == SEL_A) r_a[wr_addr] <= wr_data;
            else                 r_b[wr_addr] <= wr_data;
          end
          if (start) begin
            r_busy     <= 1'b1;
            r_acc_mode <= acc_mode;
            r_signed   <= signed_mode;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
          end
        end
        MAC: begin
          r_acc <= w_mac;
          r_k   <= r_k + CW'(1);
        end
        WRITE: begin
          r_c[w_c_idx] <= r_acc_mode ? (r_c[w_c_idx] + r_acc) : r_acc;
          r_k          <= '0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + CW'(1);
          end else begin
            r_j <= r_j + CW'(1);
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_data = r_rd_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_nxn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_mac_nxn
//  Purpose  : Self-checking bench for matrix_mac_nxn (N=3/DW=8 and N=4/DW=4 instances)
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_mac_nxn;

  localparam int     N     = 3;
  localparam int     NN    = 9;
  localparam int     ACC_W = 18;
  localparam longint MASK  = (64'd1 << ACC_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, acc_mode = 1'b0, signed_mode = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [17:0] rd_data;
  logic        busy, done;

  logic        w4_en = 1'b0, w4_sel = 1'b0, start4 = 1'b0;
  logic [3:0]  w4_addr = '0, rd4_addr = '0;
  logic [3:0]  w4_data = '0;
  logic [9:0]  rd4_data;
  logic        busy4, done4;

  int checks = 0;
  int errors = 0;

  bit [7:0] ma [NN];
  bit [7:0] mb [NN];
  longint   mc [NN];

  always #5 clk = ~clk;

  matrix_mac_nxn #(.N(3), .DW(8)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .acc_mode(acc_mode), .signed_mode(signed_mode),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  matrix_mac_nxn #(.N(4), .DW(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .wr_en(w4_en), .wr_sel(w4_sel), .wr_addr(w4_addr),
    .wr_data(w4_data), .start(start4), .acc_mode(1'b0), .signed_mode(1'b0),
    .rd_addr(rd4_addr), .rd_data(rd4_data), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input bit [7:0] v, input bit sgn);
    return (sgn && v[7]) ? longint'(v) - 256 : longint'(v);
  endfunction

  // Reference: plain matrix product over integers, then reduced modulo 2^ACC_W
  function automatic void model_run(input bit acc, input bit sgn);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) s += sx(ma[r*N+k], sgn) * sx(mb[k*N+c], sgn);
        mc[r*N+c] = ((acc ? mc[r*N+c] : 64'd0) + s) & MASK;
      end
    end
  endfunction

  task automatic load3();
    for (int i = 0; i < NN; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'(i); wr_data = ma[i];
      @(negedge clk); wr_sel = 1'b1; wr_data = mb[i];
    end
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NN; i++) begin
      @(negedge clk); rd_addr = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("%s C[%0d]", tag, i), 64'(rd_data), mc[i]);
    end
  endtask

  task automatic run3(input string tag, input bit acc, input bit sgn,
                      input int inj, input int rst_at, input bit same_wr);
    int done_edge = -1;
    int done_cnt  = 0;
    @(negedge clk);
    start = 1'b1; acc_mode = acc; signed_mode = sgn;
    if (same_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd4; wr_data = ma[4];
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    acc_mode = ~acc; signed_mode = ~sgn;
    chk({tag, " busy after start"}, 64'(busy), 64'd1);
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
      end
      if (e == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd77;
      end
      if (e == inj + 1) begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (e == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk({tag, " busy in reset"}, 64'(busy), 64'd0);
        chk({tag, " done in reset"}, 64'(done), 64'd0);
      end
      if (e == rst_at + 2) reset_n = 1'b1;
    end
    acc_mode = 1'b0; signed_mode = 1'b0;
    if (rst_at > 0) begin
      chk({tag, " done count"}, 64'(done_cnt), 64'd0);
    end else begin
      chk({tag, " done edge"}, 64'(done_edge), 64'd37);
      chk({tag, " done count"}, 64'(done_cnt), 64'd1);
    end
  endtask

  task automatic set_t1();
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'(i + 1);
      mb[i] = 8'(9 - i);
    end
  endtask

  initial begin
    int e4;
    for (int i = 0; i < NN; i++) begin
      ma[i] = '0; mb[i] = '0; mc[i] = 0;
    end

    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset rd_data", 64'(rd_data), 64'd0);
    reset_n = 1'b1;
    read_all("reset");

    set_t1();
    load3();
    run3("t1", 1'b0, 1'b0, 0, 0, 1'b0);
    model_run(1'b0, 1'b0);
    read_all("t1");

    run3("t2", 1'b1, 1'b0, 0, 0, 1'b0);
    model_run(1'b1, 1'b0);
    read_all("t2");

    for (int i = 0; i < NN; i++) begin
      ma[i] = (i % 4 == 0) ? 8'hFF : 8'h00;
      mb[i] = 8'd2;
    end
    load3();
    run3("t3s", 1'b0, 1'b1, 0, 0, 1'b0);
    model_run(1'b0, 1'b1);
    read_all("t3s");
    run3("t3u", 1'b0, 1'b0, 0, 0, 1'b0);
    model_run(1'b0, 1'b0);
    read_all("t3u");

    set_t1();
    load3();
    run3("t4", 1'b0, 1'b0, 10, 0, 1'b0);
    model_run(1'b0, 1'b0);
    read_all("t4");

    run3("t5", 1'b1, 1'b0, 0, 20, 1'b0);
    for (int i = 0; i < NN; i++) begin
      ma[i] = '0; mb[i] = '0; mc[i] = 0;
    end
    read_all("t5 zeroed");
    set_t1();
    load3();
    run3("t5r", 1'b0, 1'b0, 0, 0, 1'b0);
    model_run(1'b0, 1'b0);
    read_all("t5r");

    ma[4] = 8'd100;
    run3("wrst", 1'b0, 1'b0, 0, 0, 1'b1);
    model_run(1'b0, 1'b0);
    read_all("wrst");

    for (int t = 0; t < 3; t++) begin
      bit ra, rs;
      for (int i = 0; i < NN; i++) begin
        ma[i] = 8'($urandom_range(0, 255));
        mb[i] = 8'($urandom_range(0, 255));
      end
      ra = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      load3();
      run3($sformatf("rnd%0d", t), ra, rs, 0, 0, 1'b0);
      model_run(ra, rs);
      read_all($sformatf("rnd%0d", t));
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk); w4_en = 1'b1; w4_sel = 1'b0; w4_addr = 4'(i); w4_data = 4'hF;
      @(negedge clk); w4_sel = 1'b1;
    end
    @(negedge clk); w4_en = 1'b0; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    e4 = -1;
    for (int e = 1; e <= 100 && e4 < 0; e++) begin
      @(posedge clk); #1;
      if (done4) e4 = e;
    end
    chk("n4 done edge", 64'(e4), 64'd81);
    for (int i = 0; i < 16; i += 5) begin
      @(negedge clk); rd4_addr = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("n4 C[%0d]", i), 64'(rd4_data), 64'd900);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
